ram2x2_write_arbiter: RTL and testbench

- Two-requester round-robin arbiter for the single write port of the 2-entry x 2-bit register RAM (RAM2x2bit).
- Each requester holds a request with address and data. The arbiter grants one requester per cycle and drives the RAM write port (Write_Enable, Write_Address, Write_Data) from registers.
- A one-cycle ack returns to the winning requester. The RAM read ports are not touched by this block.

---
 rtl/ram2x2_write_arbiter.sv | 127 ++++++++++++
 tb/tb_ram2x2_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2x2_write_arbiter.sv
// Round-robin arbiter for the RAM2x2bit write port; all outputs registered.
// Optional per-requester commit counters are enabled by defining ARB_WRITE_COUNT_EN.
module ram2x2_write_arbiter #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              Write_Enable,
    output logic [ADDR_W-1:0] Write_Address,
    output logic [DATA_W-1:0] Write_Data,
`ifdef ARB_WRITE_COUNT_EN
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
`endif
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_grant_q, last_grant_d;
    logic              elig_a, elig_b;

    // A requester is masked during its own ack cycle so one request gives one write.
    always_comb begin
        elig_a = req_a && (state_q != WR_A);
        elig_b = req_b && (state_q != WR_B);
    end

    always_comb begin
        state_d      = IDLE;
        we_d         = 1'b0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        if (elig_a && (!elig_b || last_grant_q)) begin
            state_d      = WR_A;
            we_d         = 1'b1;
            ack_a_d      = 1'b1;
            waddr_d      = addr_a;
            wdata_d      = data_a;
            last_grant_d = 1'b0;
        end else if (elig_b) begin
            state_d      = WR_B;
            we_d         = 1'b1;
            ack_b_d      = 1'b1;
            waddr_d      = addr_b;
            wdata_d      = data_b;
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ack_a         = ack_a_q;
    assign ack_b         = ack_b_q;
    assign Write_Enable  = we_q;
    assign Write_Address = waddr_q;
    assign Write_Data    = wdata_q;
    assign last_grant    = last_grant_q;

`ifdef ARB_WRITE_COUNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Saturating commit counters.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (ack_a_q && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
        if (ack_b_q && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_ram2x2_write_arbiter.sv
// Bench for ram2x2_write_arbiter: scenario tasks plus a write-port scoreboard
// and a behavioural 2x2 RAM fed by the arbiter's write port.
module tb_ram2x2_write_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic       addr_a, addr_b;
    logic [1:0] data_a, data_b;
    logic       ack_a, ack_b;
    logic       Write_Enable;
    logic       Write_Address;
    logic [1:0] Write_Data;
    logic       last_grant;
`ifdef ARB_WRITE_COUNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    int errors = 0;
    int checks = 0;

    // {ack_b, ack_a, addr, data} expected on each write-port cycle
    logic [4:0] exp_q[$];
    logic [1:0] mem [2];

    always #5 clk = ~clk;

    ram2x2_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_a        (req_a),
        .addr_a       (addr_a),
        .data_a       (data_a),
        .req_b        (req_b),
        .addr_b       (addr_b),
        .data_b       (data_b),
        .ack_a        (ack_a),
        .ack_b        (ack_b),
        .Write_Enable (Write_Enable),
        .Write_Address(Write_Address),
        .Write_Data   (Write_Data),
`ifdef ARB_WRITE_COUNT_EN
        .cnt_a        (cnt_a),
        .cnt_b        (cnt_b),
`endif
        .last_grant   (last_grant)
    );

    // RAM2x2bit write side, reset on the same edge as the arbiter
    always @(posedge clk) begin
        if (reset) begin
            mem[0] <= 2'b00;
            mem[1] <= 2'b00;
        end else if (Write_Enable) begin
            mem[Write_Address] <= Write_Data;
        end
    end

    // scoreboard: every write-port cycle outside reset must match the next expectation
    always @(negedge clk) begin
        logic [4:0] got, exp;
        if (reset === 1'b0 && Write_Enable === 1'b1) begin
            got = {ack_b, ack_a, Write_Address, Write_Data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got=%b (no write expected)", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sb_write got=%b expected=%b", got, exp);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_a = 0; req_b = 0;
        addr_a = 0; addr_b = 0;
        data_a = 0; data_b = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (Write_Enable !== 1'b0) begin
            errors++; $display("FAIL rst_we got=%b expected=0", Write_Enable);
        end
        checks++;
        if ({ack_a, ack_b} !== 2'b00) begin
            errors++; $display("FAIL rst_acks got=%b expected=00", {ack_a, ack_b});
        end
        checks++;
        if (last_grant !== 1'b1) begin
            errors++; $display("FAIL rst_last_grant got=%b expected=1", last_grant);
        end
        checks++;
        if ({Write_Address, Write_Data} !== 3'b000) begin
            errors++;
            $display("FAIL rst_addr_data got=%b expected=000", {Write_Address, Write_Data});
        end
`ifdef ARB_WRITE_COUNT_EN
        checks++;
        if ({cnt_a, cnt_b} !== 16'h0) begin
            errors++; $display("FAIL rst_cnt got=%h/%h expected=0/0", cnt_a, cnt_b);
        end
`endif
    endtask

    task automatic test_single_a();
        @(posedge clk);
        #1 req_a = 1; addr_a = 0; data_a = 2'b01;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 2'b01});
        @(negedge clk);
        checks++;
        if (Write_Enable !== 1'b0) begin
            errors++; $display("FAIL single_latency we got=%b expected=0", Write_Enable);
        end
        @(negedge clk);
        checks++;
        if ({ack_a, ack_b, last_grant} !== 3'b100) begin
            errors++;
            $display("FAIL single_ack got=%b expected=100", {ack_a, ack_b, last_grant});
        end
        @(posedge clk);
        #1 req_a = 0;
        @(negedge clk);
        checks++;
        if (Write_Enable !== 1'b0) begin
            errors++; $display("FAIL single_once we got=%b expected=0", Write_Enable);
        end
        checks++;
        if (mem[0] !== 2'b01) begin
            errors++; $display("FAIL single_ram0 got=%b expected=01", mem[0]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        #1 req_a = 1; addr_a = 0; data_a = 2'b10;
        req_b = 1; addr_b = 1; data_b = 2'b11;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 2'b10});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 2'b11});
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack_a, ack_b, last_grant} !== 3'b100) begin
            errors++;
            $display("FAIL sim_first got=%b expected=100", {ack_a, ack_b, last_grant});
        end
        @(posedge clk);
        #1 req_a = 0;
        @(negedge clk);
        checks++;
        if ({ack_a, ack_b, last_grant} !== 3'b011) begin
            errors++;
            $display("FAIL sim_second got=%b expected=011", {ack_a, ack_b, last_grant});
        end
        @(posedge clk);
        #1 req_b = 0;
        @(negedge clk);
        checks++;
        if ({Write_Enable, mem[0], mem[1]} !== 5'b0_10_11) begin
            errors++;
            $display("FAIL sim_ram got=%b expected=01011", {Write_Enable, mem[0], mem[1]});
        end
    endtask

    task automatic test_fairness();
        logic prev_a = 1'b0;
        @(posedge clk);
        #1 req_a = 1; addr_a = 0; data_a = 2'b01;
        req_b = 1; addr_b = 1; data_b = 2'b10;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 1'b1, 1'b0, 2'b01});
            exp_q.push_back({1'b1, 1'b0, 1'b1, 2'b10});
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            if (k == 6) #1 req_a = 0;
            @(negedge clk);
            checks++;
            if ((ack_a ^ ack_b) !== 1'b1 || ack_a === prev_a) begin
                errors++;
                $display("FAIL fair_alt cycle=%0d got a=%b b=%b expected a=%b b=%b",
                         k, ack_a, ack_b, ~prev_a, prev_a);
            end
            prev_a = ack_a;
        end
        @(posedge clk);
        #1 req_b = 0;
        @(negedge clk);
        checks++;
        if ({Write_Enable, last_grant} !== 2'b01) begin
            errors++;
            $display("FAIL fair_end got=%b expected=01", {Write_Enable, last_grant});
        end
    endtask

    task automatic test_same_addr();
        @(posedge clk);
        #1 req_a = 1; addr_a = 1; data_a = 2'b01;
        req_b = 1; addr_b = 1; data_b = 2'b10;
        exp_q.push_back({1'b0, 1'b1, 1'b1, 2'b01});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 2'b10});
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack_a, ack_b} !== 2'b10) begin
            errors++; $display("FAIL race_first got=%b expected=10", {ack_a, ack_b});
        end
        @(posedge clk);
        #1 req_a = 0;
        @(posedge clk);
        #1 req_b = 0;
        @(negedge clk);
        checks++;
        if (mem[1] !== 2'b10) begin
            errors++; $display("FAIL race_ram1 got=%b expected=10", mem[1]);
        end
`ifdef ARB_WRITE_COUNT_EN
        checks++;
        if ({cnt_a, cnt_b} !== {8'd5, 8'd5}) begin
            errors++; $display("FAIL race_cnt got=%0d/%0d expected=5/5", cnt_a, cnt_b);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        @(posedge clk);
        #1 req_b = 1; addr_b = 0; data_b = 2'b11;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({Write_Enable, ack_b} !== 2'b11) begin
            errors++; $display("FAIL mid_wr_b got=%b expected=11", {Write_Enable, ack_b});
        end
        @(posedge clk);
        #1 reset = 1'b0; req_b = 0;
        @(negedge clk);
        checks++;
        if ({Write_Enable, ack_a, ack_b, last_grant} !== 4'b0001) begin
            errors++;
            $display("FAIL mid_rst_state got=%b expected=0001",
                     {Write_Enable, ack_a, ack_b, last_grant});
        end
        checks++;
        if ({mem[0], mem[1]} !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_ram got=%b expected=0000", {mem[0], mem[1]});
        end
`ifdef ARB_WRITE_COUNT_EN
        checks++;
        if ({cnt_a, cnt_b} !== 16'h0) begin
            errors++; $display("FAIL mid_rst_cnt got=%h/%h expected=0/0", cnt_a, cnt_b);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_simultaneous();
        test_fairness();
        test_same_addr();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
